// File: rtl/hs32_wbm_bridge_pkg.sv
// Shared constants for the HS32 Wishbone master bridge: FSM encoding and bus defaults.
package hs32_wbm_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wbm_state_e;

    localparam logic [31:0] WBM_ADDR_MASK_DEFAULT = 32'h0FFF_FFFF;
    localparam logic [3:0]  WBM_SEL_ALL           = 4'hF;

endpackage

// File: rtl/hs32_wbm_timeout.sv
// Saturating stall counter for the Wishbone master; expired_o marks the enabled
// cycle that completes 2^TIMEOUT_BITS-1 stalled cycles.
module hs32_wbm_timeout
    import hs32_wbm_bridge_pkg::*;
#(
    parameter int TIMEOUT_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [TIMEOUT_BITS-1:0] CNT_LAST = TIMEOUT_BITS'((2 ** TIMEOUT_BITS) - 2);

    logic [TIMEOUT_BITS-1:0] cnt_q;
    logic [TIMEOUT_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TIMEOUT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires one cycle early so the bridge leaves BUS on the edge the count fills.
    assign expired_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/hs32_wbm_bridge.sv
// Wishbone classic master bridge for single 32-bit HS32 transfers.
// Optional stall timeout enabled by defining HS32_WBM_TIMEOUT_EN.
module hs32_wbm_bridge
    import hs32_wbm_bridge_pkg::*;
#(
    parameter int          TIMEOUT_BITS = 8,
    parameter logic [31:0] ADDR_MASK    = WBM_ADDR_MASK_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stb,
    input  logic        i_rw,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_dtw,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_dtr,
    output logic        o_busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    wbm_state_e  state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dtr_q, dtr_d;
    logic        busy_q, busy_d;
    logic        done;
    logic        fail;

`ifdef HS32_WBM_TIMEOUT_EN
    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;

    assign tmo_clr = (state_q == ST_IDLE) && i_stb;
    assign tmo_en  = (state_q == ST_BUS) && !wbm_ack_i && !wbm_err_i;

    hs32_wbm_timeout #(
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expired_o(tmo_expired)
    );
`else
    logic unused_timeout_bits;
    assign unused_timeout_bits = (TIMEOUT_BITS > 0);
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        dtr_d   = dtr_q;
        busy_d  = busy_q;
        done    = 1'b0;
        fail    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_stb) begin
                    we_d    = i_rw;
                    adr_d   = i_addr & ADDR_MASK;
                    dat_d   = i_dtw;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // err beats ack; a real ack beats a timeout landing in the same cycle.
                if (wbm_err_i) begin
                    done = 1'b1;
                    fail = 1'b1;
                end else if (wbm_ack_i) begin
                    done = 1'b1;
`ifdef HS32_WBM_TIMEOUT_EN
                end else if (tmo_expired) begin
                    done = 1'b1;
                    fail = 1'b1;
`endif
                end
                if (done) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = fail;
                    dtr_d   = (fail || we_q) ? 32'h0 : wbm_dat_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                err_d   = 1'b0;
                dtr_d   = 32'h0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dtr_q   <= 32'h0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dtr_q   <= dtr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ack     = ack_q;
    assign o_err     = err_q;
    assign o_dtr     = dtr_q;
    assign o_busy    = busy_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = WBM_SEL_ALL;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_hs32_wbm_bridge.sv
// Self-checking bench for hs32_wbm_bridge: timeline model of each transfer plus directed literal checks.
module tb_hs32_wbm_bridge;

    localparam int          TMO_CYCLES = 15;
    localparam logic [31:0] MASK       = 32'h0FFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_stb = 1'b0;
    logic        i_rw = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_dtw = 32'h0;
    logic        o_ack, o_err, o_busy;
    logic [31:0] o_dtr;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cnt = 0;

    // Expected transfer timeline: bus cycles exp_s .. exp_s+exp_l-1, o_ack at exp_s+exp_l.
    bit          chk_en  = 1'b0;
    bit          exp_act = 1'b0;
    int unsigned exp_s   = 0;
    int unsigned exp_l   = 0;
    logic        exp_we  = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_adr = 32'h0;
    logic [31:0] exp_dat = 32'h0;
    logic [31:0] exp_dtr = 32'h0;

    hs32_wbm_bridge #(
        .TIMEOUT_BITS(4),
        .ADDR_MASK   (32'h0FFF_FFFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_stb    (i_stb),
        .i_rw     (i_rw),
        .i_addr   (i_addr),
        .i_dtw    (i_dtw),
        .o_ack    (o_ack),
        .o_err    (o_err),
        .o_dtr    (o_dtr),
        .o_busy   (o_busy),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .wbm_err_i(wbm_err_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cnt);
        end
    endtask

    always @(negedge clk) begin
        bit in_bus;
        bit ack_cyc;
        in_bus  = exp_act && (cnt >= exp_s) && (cnt < exp_s + exp_l);
        ack_cyc = exp_act && (cnt == exp_s + exp_l);
        if (chk_en) begin
            chk("cyc",  32'(wbm_cyc_o), 32'(in_bus));
            chk("stb",  32'(wbm_stb_o), 32'(in_bus));
            chk("busy", 32'(o_busy), 32'(in_bus || ack_cyc));
            chk("ack",  32'(o_ack), 32'(ack_cyc));
            chk("err",  32'(o_err), ack_cyc ? 32'(exp_err) : 32'h0);
            chk("dtr",  o_dtr, ack_cyc ? exp_dtr : 32'h0);
            chk("sel",  32'(wbm_sel_o), 32'hF);
            if (in_bus) begin
                chk("adr", wbm_adr_o, exp_adr);
                chk("dat", wbm_dat_o, exp_dat);
                chk("we",  32'(wbm_we_o), 32'(exp_we));
            end
        end
    end

    // Random request fields presented while the bridge is busy; they must be ignored.
    task automatic stray();
        i_stb  = ($urandom % 3) == 0;
        i_rw   = 1'($urandom);
        i_addr = $urandom;
        i_dtw  = $urandom;
    endtask

    // kind: 0 ack, 1 err, 2 err+ack, 3 no response (timeout). Response lands in bus cycle w+1.
    task automatic txn(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                       input int kind, input int w, input logic [31:0] rd,
                       output int o_len, output logic [31:0] o_adr,
                       output logic [31:0] o_dtr_s, output logic o_err_s, output logic o_ack_s);
        int  l;
        bit  resp;
        l       = (kind == 3) ? TMO_CYCLES : w + 1;
        exp_s   = cnt + 1;
        exp_l   = l;
        exp_we  = rw;
        exp_adr = addr & MASK;
        exp_dat = wd;
        exp_err = (kind != 0);
        exp_dtr = (kind == 0 && !rw) ? rd : 32'h0;
        exp_act = 1'b1;
        i_stb  = 1'b1;
        i_rw   = rw;
        i_addr = addr;
        i_dtw  = wd;
        @(posedge clk); #1;
        o_len = 0;
        o_adr = 32'h0;
        for (int b = 1; b <= l; b++) begin
            o_len += int'(wbm_cyc_o);
            if (b == 1) o_adr = wbm_adr_o;
            resp      = (kind != 3) && (b == w + 1);
            wbm_ack_i = resp && (kind == 0 || kind == 2);
            wbm_err_i = resp && (kind != 0);
            wbm_dat_i = resp ? rd : $urandom;
            stray();
            @(posedge clk); #1;
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        o_len  += int'(wbm_cyc_o);
        o_ack_s = o_ack;
        o_dtr_s = o_dtr;
        o_err_s = o_err;
        stray();
        @(posedge clk); #1;
        i_stb = 1'b0;
    endtask

    // Launch a request the slave never answers; the caller decides how it ends.
    task automatic start_hung(input logic [31:0] addr);
        exp_s   = cnt + 1;
        exp_l   = 32'h7FFF_FFFF;
        exp_we  = 1'b0;
        exp_adr = addr & MASK;
        exp_dat = 32'h0;
        exp_err = 1'b0;
        exp_dtr = 32'h0;
        exp_act = 1'b1;
        i_stb  = 1'b1;
        i_rw   = 1'b0;
        i_addr = addr;
        i_dtw  = 32'h0;
        @(posedge clk); #1;
        i_stb = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        reset   = 1'b1;
        exp_act = 1'b0;
        #1;
        chk("rst_cyc_async", 32'(wbm_cyc_o), 32'h0);
        chk("rst_stb_async", 32'(wbm_stb_o), 32'h0);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          len;
        logic [31:0] adr, dtr;
        logic        err, ack;
        int          kind, w;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cyc",  32'(wbm_cyc_o), 32'h0);
        chk("reset_ack",  32'(o_ack), 32'h0);
        chk("reset_busy", 32'(o_busy), 32'h0);
        chk("reset_adr",  wbm_adr_o, 32'h0);
        chk("reset_dtr",  o_dtr, 32'h0);
        chk("reset_sel",  32'(wbm_sel_o), 32'hF);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        txn(1'b0, 32'h1000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, len, adr, dtr, err, ack);
        chk("rd0_adr", adr, 32'h0000_0010);
        chk("rd0_len", 32'(len), 32'd1);
        chk("rd0_ack", 32'(ack), 32'h1);
        chk("rd0_dtr", dtr, 32'hDEAD_BEEF);
        chk("rd0_err", 32'(err), 32'h0);

        txn(1'b1, 32'h0000_0020, 32'h1234_5678, 0, 3, 32'hCAFE_F00D, len, adr, dtr, err, ack);
        chk("wr3_adr", adr, 32'h0000_0020);
        chk("wr3_len", 32'(len), 32'd4);
        chk("wr3_ack", 32'(ack), 32'h1);
        chk("wr3_dtr", dtr, 32'h0);

        txn(1'b0, 32'h0000_0044, 32'h0, 2, 1, 32'h5555_AAAA, len, adr, dtr, err, ack);
        chk("errack_len", 32'(len), 32'd2);
        chk("errack_ack", 32'(ack), 32'h1);
        chk("errack_err", 32'(err), 32'h1);
        chk("errack_dtr", dtr, 32'h0);

`ifdef HS32_WBM_TIMEOUT_EN
        txn(1'b0, 32'h0000_0080, 32'h0, 3, 0, 32'h0, len, adr, dtr, err, ack);
        chk("tmo_len", 32'(len), 32'd15);
        chk("tmo_ack", 32'(ack), 32'h1);
        chk("tmo_err", 32'(err), 32'h1);
        txn(1'b0, 32'h0000_0084, 32'h0, 0, 14, 32'h0BAD_CAFE, len, adr, dtr, err, ack);
        chk("ack_at_tmo_len", 32'(len), 32'd15);
        chk("ack_at_tmo_err", 32'(err), 32'h0);
        chk("ack_at_tmo_dtr", dtr, 32'h0BAD_CAFE);
`else
        start_hung(32'h0000_0080);
        repeat (1000) @(posedge clk);
        #1;
        chk("no_tmo_cyc", 32'(wbm_cyc_o), 32'h1);
        async_reset();
`endif

        start_hung(32'h0000_00C0);
        repeat (3) @(posedge clk);
        #1;
        async_reset();
        txn(1'b0, 32'h3000_0100, 32'h0, 0, 1, 32'hA5A5_5A5A, len, adr, dtr, err, ack);
        chk("post_rst_adr", adr, 32'h0000_0100);
        chk("post_rst_dtr", dtr, 32'hA5A5_5A5A);

        for (int t = 0; t < 40; t++) begin
`ifdef HS32_WBM_TIMEOUT_EN
            kind = $urandom % 4;
`else
            kind = $urandom % 3;
`endif
            w = $urandom_range(0, 14);
            txn(1'($urandom), $urandom, $urandom, kind, w, $urandom, len, adr, dtr, err, ack);
            repeat ($urandom % 3) @(posedge clk);
            #1;
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
